// File: rtl/mac_share_arbiter_if.sv
// Bundle of request, operand and result signals between the four requesting
// engines and the shared multiply-accumulate arbiter.
//
// Handshake: requester i transfers an operation on a rising clock edge where
// REQ[i] and GNT[i] are both high. It holds its operand slice stable while
// REQ[i] is high and GNT[i] is low. Results carry no backpressure: RES,
// RES_ID are meaningful only in a cycle where RES_VALID is high.
interface mac_share_arbiter_if;
    logic        EN;
    logic [3:0]  REQ;
    logic [31:0] A_BUS;
    logic [31:0] B_BUS;
    logic [31:0] C_BUS;
    logic [3:0]  ADD_SUB;
    logic [3:0]  GNT;
    logic [15:0] RES;
    logic        RES_VALID;
    logic [1:0]  RES_ID;
    logic        BUSY;

    // Arbiter side.
    modport slave (
        input  EN, REQ, A_BUS, B_BUS, C_BUS, ADD_SUB,
        output GNT, RES, RES_VALID, RES_ID, BUSY
    );

    // Requester / environment side.
    modport master (
        output EN, REQ, A_BUS, B_BUS, C_BUS, ADD_SUB,
        input  GNT, RES, RES_VALID, RES_ID, BUSY
    );
endinterface

// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter in front of one shared 8x8 multiply with add/subtract.
// One operation per cycle enters stage 1, moves unconditionally to stage 2,
// and is computed into the registered result the cycle after that.
module mac_share_arbiter (
    input  logic                  CLK,
    input  logic                  RST_N,
    mac_share_arbiter_if.slave    bus
);

    // Priority pointer: requester that is searched first.
    logic [1:0]  pri_q, pri_d;

    // Stage 1 registers.
    logic        v1_q, v1_d;
    logic [7:0]  a1_q, a1_d;
    logic [7:0]  b1_q, b1_d;
    logic [7:0]  c1_q, c1_d;
    logic        op1_q, op1_d;
    logic [1:0]  id1_q, id1_d;

    // Stage 2 registers.
    logic        v2_q, v2_d;
    logic [7:0]  a2_q, a2_d;
    logic [7:0]  b2_q, b2_d;
    logic [7:0]  c2_q, c2_d;
    logic        op2_q, op2_d;
    logic [1:0]  id2_q, id2_d;

    // Output registers.
    logic [15:0] res_q, res_d;
    logic [1:0]  res_id_q, res_id_d;
    logic        res_valid_q, res_valid_d;

    // Arbitration results.
    logic [3:0]  gnt;
    logic [1:0]  win_id;
    logic        win_found;
    logic [1:0]  idx;

    // Operand slice of the winning requester.
    logic [7:0]  a_sel, b_sel, c_sel;
    logic        op_sel;

    // Datapath.
    logic [15:0] mult;
    logic [15:0] res_calc;

    // Round-robin search starting at the pointer; first requester found wins.
    always_comb begin
        gnt       = 4'b0000;
        win_id    = 2'd0;
        win_found = 1'b0;
        idx       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = pri_q + 2'(k);
            if (bus.EN && bus.REQ[idx] && !win_found) begin
                gnt[idx]  = 1'b1;
                win_id    = idx;
                win_found = 1'b1;
            end
        end
    end

    // Pick the winner's operand slice out of the packed buses.
    always_comb begin
        a_sel  = bus.A_BUS[8*win_id +: 8];
        b_sel  = bus.B_BUS[8*win_id +: 8];
        c_sel  = bus.C_BUS[8*win_id +: 8];
        op_sel = bus.ADD_SUB[win_id];
    end

    // Unsigned multiply, zero-extended addend, wrap-around add or subtract.
    always_comb begin
        mult     = 16'(a2_q) * 16'(b2_q);
        res_calc = op2_q ? (16'(c2_q) + mult) : (16'(c2_q) - mult);
    end

    // Next-state for pointer, pipeline stages and output registers.
    always_comb begin
        pri_d       = win_found ? (win_id + 2'd1) : pri_q;

        v1_d        = win_found;
        a1_d        = win_found ? a_sel  : a1_q;
        b1_d        = win_found ? b_sel  : b1_q;
        c1_d        = win_found ? c_sel  : c1_q;
        op1_d       = win_found ? op_sel : op1_q;
        id1_d       = win_found ? win_id : id1_q;

        v2_d        = v1_q;
        a2_d        = a1_q;
        b2_d        = b1_q;
        c2_d        = c1_q;
        op2_d       = op1_q;
        id2_d       = id1_q;

        res_valid_d = v2_q;
        res_d       = v2_q ? res_calc : res_q;
        res_id_d    = v2_q ? id2_q    : res_id_q;
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pri_q       <= 2'd0;
            v1_q        <= 1'b0;
            a1_q        <= 8'd0;
            b1_q        <= 8'd0;
            c1_q        <= 8'd0;
            op1_q       <= 1'b0;
            id1_q       <= 2'd0;
            v2_q        <= 1'b0;
            a2_q        <= 8'd0;
            b2_q        <= 8'd0;
            c2_q        <= 8'd0;
            op2_q       <= 1'b0;
            id2_q       <= 2'd0;
            res_q       <= 16'd0;
            res_id_q    <= 2'd0;
            res_valid_q <= 1'b0;
        end else begin
            pri_q       <= pri_d;
            v1_q        <= v1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            c1_q        <= c1_d;
            op1_q       <= op1_d;
            id1_q       <= id1_d;
            v2_q        <= v2_d;
            a2_q        <= a2_d;
            b2_q        <= b2_d;
            c2_q        <= c2_d;
            op2_q       <= op2_d;
            id2_q       <= id2_d;
            res_q       <= res_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.GNT       = gnt;
    assign bus.RES       = res_q;
    assign bus.RES_ID    = res_id_q;
    assign bus.RES_VALID = res_valid_q;
    assign bus.BUSY      = v1_q | v2_q | res_valid_q;

endmodule

// File: doc/mac_share_arbiter.md
# mac_share_arbiter

Four-port round-robin arbiter and sequencer that shares one 2-register-level 8x8 multiply with add/subtract datapath between four requesters. It accepts one operation per cycle from the granted requester, pipelines it through internal operand registers, and returns a 16-bit result tagged with the requester ID after a fixed latency. It sits between the requesting engines and the arithmetic resource, and is the only path into it.

## Interface
- No parameters; widths fixed: 4 requesters, 8-bit operands, 16-bit result.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- EN  in  1  grant enable; low blocks new grants while the pipeline drains.
- REQ  in  4  per-requester request; bit i belongs to requester i.
- A_BUS  in  32  multiplicand; requester i drives [8i+7:8i].
- B_BUS  in  32  multiplier; same packing.
- C_BUS  in  32  addend/minuend; same packing.
- ADD_SUB  in  4  bit i: 1 = C+A*B, 0 = C-A*B.
- GNT  out  4  one-hot grant, combinational from REQ, EN and the priority pointer.
- RES  out  16  registered result.
- RES_VALID  out  1  one-cycle pulse per completed operation.
- RES_ID  out  2  requester index of RES.
- BUSY  out  1  high while any pipeline stage holds a valid operation.

## Operation
- Handshake: transfer for requester i occurs at a rising edge where REQ[i] & GNT[i]. The requester holds operands stable while REQ is high and ungranted. It may keep REQ high with new operands for back-to-back operations.
- Arbitration: 2-bit pointer PRI names the highest-priority requester. Search order is PRI, PRI+1, PRI+2, PRI+3 (mod 4). GNT is one-hot to the first requester with REQ high, or zero if EN=0 or REQ=0.
- After a transfer from requester i, PRI <= (i+1) mod 4. PRI is unchanged when no transfer occurs.
- Fairness: with EN high, a continuously requesting port is granted within 4 cycles.
- Pipeline:
  - Stage 1 captures A, B, C, op and ID of the winner plus valid V1.
  - Stage 2 copies stage 1 into V2 unconditionally every cycle.
  - Output stage computes from stage 2 and registers RES and RES_ID when V2=1. RES_VALID <= V2.
- No stalls. The pipeline advances every cycle and there is no output backpressure.
- Arithmetic:
  - mult = A*B, unsigned, 16 bits.
  - C is zero-extended to 16 bits.
  - RES = (C + mult) mod 2^16 when op=1, else (C - mult) mod 2^16 (two's-complement wrap, no saturation, no flags).
- RES and RES_ID hold their last values when RES_VALID=0.
- BUSY = V1 | V2 | RES_VALID.
- EN dropped mid-stream: already accepted operations complete normally. GNT goes to 0 in the same cycle EN is low.
- Reset (async, any time):
  - PRI=0; V1=V2=0; all stage registers 0.
  - RES=0, RES_ID=0, RES_VALID=0, BUSY=0.
  - In-flight operations are discarded, with no partial result.
  - GNT is combinational, so it may assert in the first cycle after RST_N rises if REQ and EN are high.

## Timing
- Latency: an operation transferred at edge k gives RES_VALID high in the cycle after edge k+2. That is 3 cycles from REQ/GNT to result.
- Throughput: one operation per cycle across all ports. Results emerge in grant order.
- GNT depends combinationally on REQ and EN in the same cycle. There is no combinational path from REQ to RES, RES_VALID, RES_ID or BUSY.
- All outputs except GNT are registered.

## Test plan
- Single op, port 0: REQ=0001, A=12, B=10, C=100, ADD_SUB[0]=1, granted at edge k.
  - RES_VALID after edge k+2 with RES=0x00DC, RES_ID=0.
  - BUSY high for 3 cycles.
- Subtract wrap, port 2: A=3, B=4, C=5, op=0 -> RES=0xFFF9, RES_ID=2.
- Max add: A=B=C=255, op=1 -> RES=0xFF00.
- All four requesting continuously from reset with distinct operands:
  - GNT sequence is 0001, 0010, 0100, 1000, 0001, ...
  - RES_ID sequence is 0,1,2,3,0,... with back-to-back RES_VALID and each result correct.
- PRI=2 after a grant to port 1, then REQ=1011 -> grant order 3, 0, 1.
- EN and reset:
  - EN low with REQ=1111: GNT=0000, and the 2 operations accepted before EN fell still produce RES_VALID then BUSY=0.
  - Assert RST_N low one cycle after a transfer: RES_VALID never pulses for it, and RES=0, RES_ID=0, PRI=0 immediately.
